// File: rtl/ext_mem_rr_merge_pkg.sv
// Shared native-bus layout, arbitration mode codes and merge FSM states.
// Request word is {valid, addr, wdata, wstrb}; response word is {rdata, ready}.
package ext_mem_rr_merge_pkg;

  localparam int MODE_RR    = 0;
  localparam int MODE_FIXED = 1;

  localparam int RESP_READY_BIT = 0;
  localparam int RESP_RDATA_LSB = 1;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } merge_state_e;

  function automatic int req_w(input int addr_w, input int data_w);
    return 1 + addr_w + data_w + data_w / 8;
  endfunction

  function automatic int resp_w(input int data_w);
    return data_w + 1;
  endfunction

  function automatic int req_valid_bit(input int addr_w, input int data_w);
    return addr_w + data_w + data_w / 8;
  endfunction

  function automatic int req_addr_lsb(input int data_w);
    return data_w + data_w / 8;
  endfunction

  function automatic int req_wdata_lsb(input int data_w);
    return data_w / 8;
  endfunction

  // Index width never drops below one bit, even for a single master.
  function automatic int gid_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/ext_mem_rr_merge_if.sv
// Native-bus bundle between N requesters, the merge and the L2 slave.
// slave = merge side, master = requesters plus L2 side.
interface ext_mem_rr_merge_if
  import ext_mem_rr_merge_pkg::*;
#(
  parameter int N_MASTERS = 2,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 256
);
  localparam int REQ_W  = req_w(ADDR_W, DATA_W);
  localparam int RESP_W = resp_w(DATA_W);

  logic [N_MASTERS-1:0][REQ_W-1:0]  m_req;
  logic [N_MASTERS-1:0][RESP_W-1:0] m_resp;
  logic [REQ_W-1:0]                 s_req;
  logic [RESP_W-1:0]                s_resp;

  modport slave  (input  m_req, s_resp, output m_resp, s_req);
  modport master (output m_req, s_resp, input  m_resp, s_req);
endinterface

// File: rtl/ext_mem_rr_arbiter.sv
// Combinational rotating-priority encoder; fixed mode searches from index 0.
module ext_mem_rr_arbiter #(
  parameter int N     = 2,
  parameter int GID_W = 1
) (
  input  logic [N-1:0]     req,
  input  logic [GID_W-1:0] rr_ptr,
  input  logic             mode,
  output logic [GID_W-1:0] winner,
  output logic             any
);
  always_comb begin
    int idx;
    idx    = 0;
    winner = '0;
    any    = 1'b0;
    for (int i = 0; i < N; i++) begin
      idx = (mode ? 0 : int'(rr_ptr)) + i;
      if (idx >= N) idx = idx - N;
      if (!any && req[idx]) begin
        any    = 1'b1;
        winner = GID_W'(idx);
      end
    end
  end
endmodule

// File: rtl/ext_mem_rr_merge.sv
// N-master native-bus merge in front of L2: grant held for up to BURST_MAX
// transactions, responses routed only to the owner.
module ext_mem_rr_merge
  import ext_mem_rr_merge_pkg::*;
#(
  parameter int N_MASTERS = 2,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 256,
  parameter int BURST_MAX = 16,
  parameter int MODE      = MODE_RR
) (
  input  logic                         clk,
  input  logic                         rst,
  ext_mem_rr_merge_if.slave            bus,
  output logic                         busy,
  output logic [gid_w(N_MASTERS)-1:0]  grant_id
);
  localparam int GID_W = gid_w(N_MASTERS);
  localparam int REQ_W = req_w(ADDR_W, DATA_W);
  localparam int VLD   = req_valid_bit(ADDR_W, DATA_W);
  localparam int BC_W  = $clog2(BURST_MAX + 1);

  merge_state_e         state;
  logic [GID_W-1:0]     rr_ptr;
  logic [GID_W-1:0]     winner;
  logic [BC_W-1:0]      burst_cnt;
  logic [N_MASTERS-1:0] req_vld;
  logic                 any_req;
  logic [REQ_W-1:0]     gnt_req;
  logic                 s_ready;
  logic                 gnt_ready;

  always_comb begin
    req_vld = '0;
    for (int i = 0; i < N_MASTERS; i++) req_vld[i] = bus.m_req[i][VLD];
  end

  ext_mem_rr_arbiter #(.N(N_MASTERS), .GID_W(GID_W)) u_arb (
    .req    (req_vld),
    .rr_ptr (rr_ptr),
    .mode   (MODE == MODE_FIXED),
    .winner (winner),
    .any    (any_req)
  );

  // IDLE drives nothing, so m_req never reaches s_req through the arbiter.
  assign gnt_req   = bus.m_req[grant_id];
  assign s_ready   = bus.s_resp[RESP_READY_BIT];
  assign gnt_ready = (state == ST_GRANT) && s_ready;
  assign bus.s_req = (state == ST_GRANT) ? gnt_req : '0;

  always_comb begin
    bus.m_resp = '0;
    if (gnt_ready) bus.m_resp[grant_id] = bus.s_resp;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      rr_ptr    <= '0;
      grant_id  <= '0;
      burst_cnt <= '0;
      busy      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (any_req) begin
          grant_id  <= winner;
          rr_ptr    <= (winner == GID_W'(N_MASTERS - 1)) ? '0 : winner + 1'b1;
          burst_cnt <= '0;
          state     <= ST_GRANT;
          busy      <= 1'b1;
        end
        ST_GRANT: begin
          if (s_ready) burst_cnt <= burst_cnt + 1'b1;
          // Release on a full burst or when the owner stops requesting.
          if ((s_ready && burst_cnt == BC_W'(BURST_MAX - 1)) || !gnt_req[VLD]) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_ext_mem_rr_merge.sv
// Directed bench: single read, spurious ready, reset mid-grant and burst
// affinity on u1; round-robin on u0; fixed priority with three masters on u2.
module tb_ext_mem_rr_merge;
  localparam int AW     = 32;
  localparam int DW     = 64;
  localparam int REQ_W  = 1 + AW + DW + DW / 8;
  localparam int RESP_W = DW + 1;

  localparam logic [DW-1:0] RD_AUTO = 64'h0123_4567_89AB_CDEF;
  localparam logic [DW-1:0] RD_A5   = 64'hA5A5_A5A5_A5A5_A5A5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  logic       busy0, busy1, busy2;
  logic [0:0] gid0, gid1;
  logic [1:0] gid2;
  logic              auto1;
  logic [RESP_W-1:0] man_resp1;

  ext_mem_rr_merge_if #(.N_MASTERS(2), .ADDR_W(AW), .DATA_W(DW)) if0 ();
  ext_mem_rr_merge_if #(.N_MASTERS(2), .ADDR_W(AW), .DATA_W(DW)) if1 ();
  ext_mem_rr_merge_if #(.N_MASTERS(3), .ADDR_W(AW), .DATA_W(DW)) if2 ();

  ext_mem_rr_merge #(.N_MASTERS(2), .ADDR_W(AW), .DATA_W(DW), .BURST_MAX(1), .MODE(0)) u0 (
    .clk(clk), .rst(rst), .bus(if0.slave), .busy(busy0), .grant_id(gid0));
  ext_mem_rr_merge #(.N_MASTERS(2), .ADDR_W(AW), .DATA_W(DW), .BURST_MAX(4), .MODE(0)) u1 (
    .clk(clk), .rst(rst), .bus(if1.slave), .busy(busy1), .grant_id(gid1));
  ext_mem_rr_merge #(.N_MASTERS(3), .ADDR_W(AW), .DATA_W(DW), .BURST_MAX(1), .MODE(1)) u2 (
    .clk(clk), .rst(rst), .bus(if2.slave), .busy(busy2), .grant_id(gid2));

  // Always-ready slaves answer in the same cycle they are asked.
  assign if0.s_resp = {RD_AUTO, if0.s_req[REQ_W-1]};
  assign if2.s_resp = {RD_AUTO, if2.s_req[REQ_W-1]};
  assign if1.s_resp = auto1 ? {RD_AUTO, if1.s_req[REQ_W-1]} : man_resp1;

  function automatic logic [REQ_W-1:0] mkreq(input logic [AW-1:0] a, input logic [DW-1:0] d);
    return {1'b1, a, d, 8'hFF};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  logic [REQ_W-1:0] r_rd, r_b, r_w, ra0, ra1, ra2;
  logic [REQ_W-1:0] rq [6];

  initial begin
    r_rd = mkreq(32'h40,  64'h0);
    r_b  = mkreq(32'h80,  64'h1111);
    r_w  = mkreq(32'h200, 64'h2222);
    ra0  = mkreq(32'h300, 64'h30);
    ra1  = mkreq(32'h340, 64'h31);
    ra2  = mkreq(32'h380, 64'h32);
    for (int k = 0; k < 6; k++) rq[k] = mkreq(32'h1000 + 32'(k * 64), 64'(k));
    if0.m_req = '0; if1.m_req = '0; if2.m_req = '0;
    auto1 = 1'b0; man_resp1 = '0;

    // reset state
    step(); step();
    chk("rst_busy1", busy1, 1'b0);
    chk("rst_gid1", gid1, 1'b0);
    chk("rst_sreq1", if1.s_req, '0);
    chk("rst_mresp1_0", if1.m_resp[0], '0);
    chk("rst_busy0", busy0, 1'b0);
    chk("rst_busy2", busy2, 1'b0);
    rst = 1'b0;

    // single read: ready 3 cycles after s_req.valid
    if1.m_req[0] = r_rd; #1;
    chk("rd_idle_sreq", if1.s_req, '0);
    chk("rd_idle_busy", busy1, 1'b0);
    step();
    chk("rd_busy", busy1, 1'b1);
    chk("rd_gid", gid1, 1'b0);
    chk("rd_sreq", if1.s_req, r_rd);
    chk("rd_wait_resp0", if1.m_resp[0], '0);
    step(); step(); step();
    man_resp1 = {RD_A5, 1'b1}; #1;
    chk("rd_resp0", if1.m_resp[0], {RD_A5, 1'b1});
    chk("rd_resp1", if1.m_resp[1], '0);
    step();
    if1.m_req[0] = '0; man_resp1 = '0; #1;
    chk("rd_drop_sreq", if1.s_req, '0);
    chk("rd_drop_busy", busy1, 1'b1);
    step();
    chk("rd_release", busy1, 1'b0);

    // spurious ready in IDLE
    man_resp1 = {64'hFF, 1'b1}; #1;
    chk("spur_resp0", if1.m_resp[0], '0);
    chk("spur_resp1", if1.m_resp[1], '0);
    step();
    chk("spur_busy", busy1, 1'b0);
    chk("spur_sreq", if1.s_req, '0);
    man_resp1 = '0;

    // reset during GRANT, late slave ready
    if1.m_req[1] = r_b;
    step();
    chk("mrst_gid", gid1, 1'b1);
    chk("mrst_busy", busy1, 1'b1);
    rst = 1'b1; if1.m_req[1] = '0;
    step();
    rst = 1'b0;
    chk("mrst_busy_after", busy1, 1'b0);
    chk("mrst_gid_after", gid1, 1'b0);
    chk("mrst_sreq_after", if1.s_req, '0);
    step();
    man_resp1 = {RD_A5, 1'b1}; #1;
    chk("mrst_late_resp0", if1.m_resp[0], '0);
    chk("mrst_late_resp1", if1.m_resp[1], '0);
    step();
    chk("mrst_idle", busy1, 1'b0);
    man_resp1 = '0;

    // burst affinity: m1 six requests, m0 waiting, BURST_MAX=4
    auto1 = 1'b1;
    if1.m_req[1] = rq[0];
    step();
    if1.m_req[0] = r_w; #1;
    chk("bu_gid", gid1, 1'b1);
    chk("bu_sreq0", if1.s_req, rq[0]);
    chk("bu_resp1", if1.m_resp[1], {RD_AUTO, 1'b1});
    chk("bu_resp0_quiet", if1.m_resp[0], '0);
    for (int k = 1; k < 4; k++) begin
      step();
      if1.m_req[1] = rq[k]; #1;
      chk("bu_sreq_nobubble", if1.s_req, rq[k]);
      chk("bu_busy", busy1, 1'b1);
    end
    step();
    if1.m_req[1] = rq[4]; #1;
    chk("bu_forced_release", busy1, 1'b0);
    chk("bu_gap_sreq", if1.s_req, '0);
    step();
    chk("bu_m0_gid", gid1, 1'b0);
    chk("bu_m0_sreq", if1.s_req, r_w);
    step();
    if1.m_req[0] = '0; #1;
    chk("bu_m0_drop_sreq", if1.s_req, '0);
    chk("bu_m0_drop_busy", busy1, 1'b1);
    step();
    chk("bu_m0_release", busy1, 1'b0);
    step();
    chk("bu_m1_again_gid", gid1, 1'b1);
    chk("bu_m1_sreq4", if1.s_req, rq[4]);
    step();
    if1.m_req[1] = rq[5]; #1;
    chk("bu_m1_sreq5", if1.s_req, rq[5]);
    step();
    if1.m_req[1] = '0; #1;
    chk("bu_m1_end_sreq", if1.s_req, '0);
    step();
    chk("bu_m1_release", busy1, 1'b0);
    auto1 = 1'b0;

    // round-robin, BURST_MAX=1: grants 0,1,0,1 with idle gaps
    if0.m_req[0] = ra0; if0.m_req[1] = ra1;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("rr_gid", gid0, 128'(k % 2));
      chk("rr_busy", busy0, 1'b1);
      chk("rr_sreq", if0.s_req, (k % 2 == 1) ? ra1 : ra0);
      step();
      chk("rr_gap", busy0, 1'b0);
    end
    if0.m_req = '0;

    // fixed priority, three masters: m0 wins until it drops
    if2.m_req[0] = ra0; if2.m_req[2] = ra2;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("fp_gid0", gid2, 2'd0);
      chk("fp_busy", busy2, 1'b1);
      chk("fp_resp2_quiet", if2.m_resp[2], '0);
      step();
      chk("fp_gap", busy2, 1'b0);
    end
    if2.m_req[0] = '0;
    step();
    chk("fp_gid2", gid2, 2'd2);
    chk("fp_sreq2", if2.s_req, ra2);
    chk("fp_resp2", if2.m_resp[2], {RD_AUTO, 1'b1});
    step();
    chk("fp_release", busy2, 1'b0);
    if2.m_req = '0;

    step();
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/ext_mem_rr_merge.md
# ext_mem_rr_merge

Parametrised N-master merge for the MIG-width native bus, placed between the first-level caches' back-ends and the L2 cache inside the external-memory subsystem. It arbitrates among `N_MASTERS` native-bus requesters by round-robin or fixed priority. A granted master keeps the grant across back-to-back transactions, up to `BURST_MAX`, so cache-line refills are not interleaved. Responses are routed only to the owning master.

## Interface
Parameters:
- `N_MASTERS`, 2: number of requesters, ≥1.
- `ADDR_W`, 32: native-bus address width.
- `DATA_W`, 256: bus data width (MIG bus width), multiple of 8.
- `BURST_MAX`, 16: maximum consecutive transactions per grant, ≥1.
- `MODE`, 0: 0 = round-robin, 1 = fixed priority (lowest index wins).

Derived widths:
- `REQ_W` = 1+`ADDR_W`+`DATA_W`+`DATA_W`/8, packed {valid, addr, wdata, wstrb}, with valid at the MSB.
- `RESP_W` = `DATA_W`+1, packed {rdata, ready}, with ready at bit 0.

Ports:
- `clk`  in  1  sole clock.
- `rst`  in  1  reset, synchronous, active-high.
- `m_req`  in  `N_MASTERS`*`REQ_W`  master requests; master i occupies slice i.
- `m_resp`  out  `N_MASTERS`*`RESP_W`  master responses.
- `s_req`  out  `REQ_W`  request to slave (L2).
- `s_resp`  in  `RESP_W`  slave response.
- `busy`  out  1  high in GRANT state.
- `grant_id`  out  clog2(max(`N_MASTERS`,2))  currently or last granted master.

## Operation
Native-bus rules:
- A master holds valid and its fields stable until it sees ready.
- Ready is a one-cycle pulse; rdata is valid only with ready.
- Valid may stay high after ready to present the next request.

State machine (IDLE, GRANT):
- **IDLE**
  - `s_req` = 0.
  - If any master valid is high, choose the winner, register it in `grant_id`, clear `burst_cnt`, and go to GRANT.
  - If no master valid is high, stay in IDLE.
- **GRANT**
  - `s_req` = `m_req[grant_id]`.
  - On `s_resp.ready`: drive `m_resp[grant_id]` = `s_resp`, and increment `burst_cnt`.
  - If the incremented `burst_cnt` == `BURST_MAX`, go to IDLE (forced release).
  - If the granted master's valid is low, `s_req.valid` = 0 and go to IDLE the next cycle.
- All non-granted `m_resp` slices are 0 at all times; rdata is never broadcast.

Arbitration:
- Round-robin pointer `rr_ptr` is set to `grant_id`+1 mod `N_MASTERS` on every grant.
- Search starts at `rr_ptr` and wraps.
- `MODE`=1 ignores `rr_ptr`.

Boundary conditions:
- `s_resp.ready` while in IDLE: ignored; no master sees ready.
- `N_MASTERS`=1: the arbiter is trivial; the FSM still applies.
- `BURST_MAX`=1: re-arbitration after every transaction.
- `burst_cnt` width is clog2(`BURST_MAX`+1); it never wraps.
- A master dropping valid in the cycle after ready is the normal end of its burst, not an error.

## Timing
Reset:
- `rst` high at a clock edge puts the block in IDLE with `rr_ptr`=0, `grant_id`=0, `burst_cnt`=0.
- Reset values of outputs: `s_req`=0, `m_resp`=0, `busy`=0, `grant_id`=0.
- Reset mid-transaction abandons the transaction; a late slave ready is ignored.

Latency:
- Arbitration costs one cycle: valid seen in IDLE at cycle t gives `s_req.valid` at t+1.
- Back-to-back requests within a grant add no bubble.
- Response path is combinational: `s_resp.ready` reaches the owner in the same cycle.
- There is no combinational path from `m_req` valid to the grant decision into `s_req` in IDLE.
- After a release, the next grant is in IDLE one cycle later, giving a one-cycle gap between masters.

## Structure
- Shared package / header holds:
  - native-bus field offsets and the `REQ_W`/`RESP_W` formulas, reused by the caches and the merge;
  - MODE encodings;
  - FSM state encodings.
- One sub-module, `ext_mem_rr_arbiter`: combinational rotating-priority encoder with inputs (req vector, `rr_ptr`, mode) and outputs (winner index, any).
- The top level holds the FSM, `burst_cnt`, `rr_ptr`, and request/response muxing.

## Test plan
- **Single read:** m0 valid, addr 0x40, slave ready 3 cycles after `s_req.valid` with rdata 0xA5..A5 → `s_req.valid` at t+1; m0 ready plus rdata in the same cycle as slave ready; m1 response stays 0.
- **Round-robin:** `MODE`=0, `BURST_MAX`=1, m0 and m1 continuously valid, slave ready every cycle it is asked → grants alternate 0,1,0,1; one idle cycle between grants.
- **Burst affinity:** `BURST_MAX`=4, m1 issues 6 back-to-back requests while m0 waits → m1 gets 4 with no bubbles, then m0 gets 1, then m1 gets its remaining 2.
- **Fixed priority:** `MODE`=1, `N_MASTERS`=3, m0 and m2 always valid, `BURST_MAX`=1 → m0 always granted; m2 granted only once m0 drops valid.
- **Reset mid-transaction:** `rst` in GRANT before ready, slave ready arrives 2 cycles later → all outputs 0 from the cycle after reset; no master sees ready.
- **Spurious ready:** `s_resp.ready`=1 with rdata 0xFF while in IDLE → every `m_resp` slice stays 0; state stays IDLE.
